// File: rtl/switch_mcu_ex_branch_resolve.sv
// Execute-stage branch/jump resolver: condition, target, flush code and fetch redirect handshake.
// Optional statistics counters are built in when SWITCH_MCU_BR_STATS_EN is defined.
module switch_mcu_ex_branch_resolve #(
  parameter int PC_W          = 16,
  parameter int DATA_W        = 8,
  parameter int RESOLVE_CYCLE = 3
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [3:0]        in_cycle_cnt,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic [2:0]        in_br_op,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [7:0]        in_offset,
  input  logic [PC_W-1:0]   in_reg_target,
  input  logic              in_redirect_ack,
`ifdef SWITCH_MCU_BR_STATS_EN
  input  logic              in_stats_clr,
  output logic [15:0]       out_taken_cnt,
  output logic [15:0]       out_flush_cyc_cnt,
`endif
  output logic [1:0]        out_flush,
  output logic              out_redirect_valid,
  output logic [PC_W-1:0]   out_redirect_pc,
  output logic              out_overrun
);

  localparam logic [3:0] RES_CNT   = 4'(RESOLVE_CYCLE);
  localparam logic [3:0] FLUSH_CNT = 4'd4;

  localparam logic [1:0] FLUSH_DISABLE = 2'd0;
  localparam logic [1:0] FLUSH_CYCLE1  = 2'd1;
  localparam logic [1:0] FLUSH_CYCLE2  = 2'd2;

  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BLTU = 3'b011;
  localparam logic [2:0] OP_BGEU = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_JR   = 3'b110;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  // Saturating 16-bit accumulate used by the statistics counters.
  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic signed [PC_W-1:0] offset_ext_p0;
  logic [PC_W-1:0]        target_p0;
  logic                   taken_p0;
  logic                   jump_p0;
  logic                   resolve_p0;
  logic                   take_p0;
  logic [1:0]             flush_code_p0;

  state_t                 state_p1;
  state_t                 state_nxt;
  logic                   load_pc;
  logic                   overrun_set;
  logic [1:0]             flush_p1;
  logic [PC_W-1:0]        redir_pc_p1;
  logic                   overrun_p1;

  // Stage p0: combinational resolve of the instruction presented at the resolve phase
  assign offset_ext_p0 = {{(PC_W-8){in_offset[7]}}, in_offset};
  assign resolve_p0    = (in_cycle_cnt == RES_CNT) && in_valid && !in_stall;
  assign take_p0       = resolve_p0 && taken_p0;

  always_comb begin
    taken_p0 = 1'b0;
    jump_p0  = 1'b0;
    case (in_br_op)
      OP_BEQ:  taken_p0 = (in_opa == in_opb);
      OP_BNE:  taken_p0 = (in_opa != in_opb);
      OP_BLTU: taken_p0 = (in_opa <  in_opb);
      OP_BGEU: taken_p0 = (in_opa >= in_opb);
      OP_JMP, OP_JR: begin
        taken_p0 = 1'b1;
        jump_p0  = 1'b1;
      end
      default: taken_p0 = 1'b0;
    endcase
  end

  always_comb begin
    target_p0 = in_pc + PC_W'(1) + offset_ext_p0;
    if (in_br_op == OP_JR)
      target_p0 = in_reg_target;
  end

  always_comb begin
    flush_code_p0 = FLUSH_DISABLE;
    if (taken_p0)
      flush_code_p0 = jump_p0 ? FLUSH_CYCLE1 : FLUSH_CYCLE2;
  end

  // Redirect FSM: a taken resolve while a request is pending replaces the target
  always_comb begin
    state_nxt   = state_p1;
    load_pc     = 1'b0;
    overrun_set = 1'b0;
    case (state_p1)
      ST_IDLE: begin
        if (take_p0) begin
          load_pc   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (take_p0) begin
          load_pc     = 1'b1;
          overrun_set = !in_redirect_ack;
        end else if (in_redirect_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: registered flush code, redirect request and sticky overrun
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_p1    <= ST_IDLE;
      flush_p1    <= FLUSH_DISABLE;
      redir_pc_p1 <= '0;
      overrun_p1  <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (resolve_p0)
        flush_p1 <= flush_code_p0;
      else if (in_cycle_cnt == FLUSH_CNT)
        flush_p1 <= FLUSH_DISABLE;
      if (load_pc)
        redir_pc_p1 <= target_p0;
      if (overrun_set)
        overrun_p1 <= 1'b1;
    end
  end

  assign out_flush          = flush_p1;
  assign out_redirect_valid = (state_p1 == ST_REQ);
  assign out_redirect_pc    = redir_pc_p1;
  assign out_overrun        = overrun_p1;

`ifdef SWITCH_MCU_BR_STATS_EN
  logic [15:0] taken_cnt_p1;
  logic [15:0] flush_cyc_cnt_p1;

  // Clear wins over a same-edge increment
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      taken_cnt_p1     <= '0;
      flush_cyc_cnt_p1 <= '0;
    end else if (in_stats_clr) begin
      taken_cnt_p1     <= '0;
      flush_cyc_cnt_p1 <= '0;
    end else if (take_p0) begin
      taken_cnt_p1     <= sat_add16(taken_cnt_p1, 2'd1);
      flush_cyc_cnt_p1 <= sat_add16(flush_cyc_cnt_p1, flush_code_p0);
    end
  end

  assign out_taken_cnt     = taken_cnt_p1;
  assign out_flush_cyc_cnt = flush_cyc_cnt_p1;
`endif

endmodule

// File: tb/tb_switch_mcu_ex_branch_resolve.sv
// Directed bench for switch_mcu_ex_branch_resolve with a rule-level reference model checked every cycle.
module tb_switch_mcu_ex_branch_resolve;
  localparam int PC_W   = 16;
  localparam int DATA_W = 8;

  logic              in_clk = 1'b0;
  logic              in_rst = 1'b0;
  logic [3:0]        in_cycle_cnt = 4'd0;
  logic              in_valid = 1'b0;
  logic              in_stall = 1'b0;
  logic [2:0]        in_br_op = 3'd0;
  logic [DATA_W-1:0] in_opa = '0;
  logic [DATA_W-1:0] in_opb = '0;
  logic [PC_W-1:0]   in_pc = '0;
  logic [7:0]        in_offset = '0;
  logic [PC_W-1:0]   in_reg_target = '0;
  logic              in_redirect_ack = 1'b0;
  logic [1:0]        out_flush;
  logic              out_redirect_valid;
  logic [PC_W-1:0]   out_redirect_pc;
  logic              out_overrun;
`ifdef SWITCH_MCU_BR_STATS_EN
  logic              in_stats_clr = 1'b0;
  logic [15:0]       out_taken_cnt;
  logic [15:0]       out_flush_cyc_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_flush = 0, m_valid = 0, m_pc = 0, m_ovr = 0, m_tk_cnt = 0, m_fl_cnt = 0;

  switch_mcu_ex_branch_resolve #(.PC_W(PC_W), .DATA_W(DATA_W), .RESOLVE_CYCLE(3)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_cycle_cnt(in_cycle_cnt),
    .in_valid(in_valid), .in_stall(in_stall), .in_br_op(in_br_op),
    .in_opa(in_opa), .in_opb(in_opb), .in_pc(in_pc), .in_offset(in_offset),
    .in_reg_target(in_reg_target), .in_redirect_ack(in_redirect_ack),
`ifdef SWITCH_MCU_BR_STATS_EN
    .in_stats_clr(in_stats_clr), .out_taken_cnt(out_taken_cnt),
    .out_flush_cyc_cnt(out_flush_cyc_cnt),
`endif
    .out_flush(out_flush), .out_redirect_valid(out_redirect_valid),
    .out_redirect_pc(out_redirect_pc), .out_overrun(out_overrun)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies the architectural rules to what the DUT sees at one clock edge.
  task automatic model_edge();
    bit res, tk;
    int fl, tgt, off;
    res = (in_cycle_cnt == 4'd3) && in_valid && !in_stall;
    off = $signed(in_offset);
    tgt = (int'(in_pc) + 1 + off) & 32'hFFFF;
    tk  = 1'b0;
    fl  = 0;
    case (in_br_op)
      3'd1: tk = (in_opa == in_opb);
      3'd2: tk = (in_opa != in_opb);
      3'd3: tk = (int'(in_opa) <  int'(in_opb));
      3'd4: tk = (int'(in_opa) >= int'(in_opb));
      3'd5: begin tk = 1'b1; fl = 1; end
      3'd6: begin tk = 1'b1; fl = 1; tgt = int'(in_reg_target); end
      default: tk = 1'b0;
    endcase
    if (tk && fl == 0) fl = 2;
    if (!tk) fl = 0;
    if (res) m_flush = fl;
    else if (in_cycle_cnt == 4'd4) m_flush = 0;
`ifdef SWITCH_MCU_BR_STATS_EN
    if (in_stats_clr) begin
      m_tk_cnt = 0;
      m_fl_cnt = 0;
    end else if (res && tk) begin
      m_tk_cnt = (m_tk_cnt + 1 > 65535) ? 65535 : m_tk_cnt + 1;
      m_fl_cnt = (m_fl_cnt + fl > 65535) ? 65535 : m_fl_cnt + fl;
    end
`endif
    if (res && tk) begin
      if (m_valid == 1 && !in_redirect_ack) m_ovr = 1;
      m_valid = 1;
      m_pc    = tgt;
    end else if (m_valid == 1 && in_redirect_ack) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
    in_cycle_cnt = (in_cycle_cnt + 4'd1) & 4'd7;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] pc, input logic [7:0] off, input logic [15:0] rt,
                       input logic stall, input logic ack);
    int guard = 0;
    while (in_cycle_cnt != 4'd3 && guard < 16) begin
      tick();
      guard++;
    end
    in_br_op = op; in_opa = a; in_opb = b; in_pc = pc; in_offset = off;
    in_reg_target = rt; in_stall = stall; in_redirect_ack = ack; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_stall = 1'b0; in_redirect_ack = 1'b0;
  endtask

  task automatic do_ack();
    in_redirect_ack = 1'b1;
    tick();
    in_redirect_ack = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(posedge in_clk or negedge in_rst);
        if (!in_rst) begin
          m_flush = 0; m_valid = 0; m_pc = 0; m_ovr = 0; m_tk_cnt = 0; m_fl_cnt = 0;
        end else begin
          model_edge();
        end
      end
      forever begin
        @(negedge in_clk);
        chk("cyc_flush", 32'(out_flush), 32'(m_flush));
        chk("cyc_redirect_valid", 32'(out_redirect_valid), 32'(m_valid));
        chk("cyc_redirect_pc", 32'(out_redirect_pc), 32'(m_pc));
        chk("cyc_overrun", 32'(out_overrun), 32'(m_ovr));
`ifdef SWITCH_MCU_BR_STATS_EN
        chk("cyc_taken_cnt", 32'(out_taken_cnt), 32'(m_tk_cnt));
        chk("cyc_flush_cyc_cnt", 32'(out_flush_cyc_cnt), 32'(m_fl_cnt));
`endif
      end
    join_none

    #3;
    chk("rst_flush", 32'(out_flush), 0);
    chk("rst_valid", 32'(out_redirect_valid), 0);
    chk("rst_pc", 32'(out_redirect_pc), 0);
    chk("rst_overrun", 32'(out_overrun), 0);
    @(negedge in_clk);
    in_rst = 1'b1;
    tick();

    issue(3'd1, 8'h3C, 8'h3C, 16'h0010, 8'd4, 16'h0, 1'b0, 1'b0);
    chk("beq_flush", 32'(out_flush), 2);
    chk("beq_valid", 32'(out_redirect_valid), 1);
    chk("beq_pc", 32'(out_redirect_pc), 32'h0015);
    tick();
    chk("beq_flush_after", 32'(out_flush), 0);
    chk("beq_valid_held", 32'(out_redirect_valid), 1);
    do_ack();
    chk("beq_acked", 32'(out_redirect_valid), 0);

    issue(3'd2, 8'h07, 8'h07, 16'h0020, 8'd4, 16'h0, 1'b0, 1'b0);
    chk("bne_flush", 32'(out_flush), 0);
    chk("bne_valid", 32'(out_redirect_valid), 0);
    issue(3'd3, 8'h80, 8'h01, 16'h0030, 8'd4, 16'h0, 1'b0, 1'b0);
    chk("bltu_unsigned_flush", 32'(out_flush), 0);
    chk("bltu_unsigned_valid", 32'(out_redirect_valid), 0);

    issue(3'd4, 8'h80, 8'h01, 16'h0040, 8'h10, 16'h0, 1'b0, 1'b0);
    chk("bgeu_flush", 32'(out_flush), 2);
    chk("bgeu_pc", 32'(out_redirect_pc), 32'h0051);
    do_ack();
    issue(3'd3, 8'h01, 8'h80, 16'h0040, 8'hFE, 16'h0, 1'b0, 1'b0);
    chk("bltu_taken_pc", 32'(out_redirect_pc), 32'h003F);
    do_ack();

    issue(3'd5, 8'h00, 8'h00, 16'h0005, 8'hF0, 16'h0, 1'b0, 1'b0);
    chk("jmp_wrap_pc", 32'(out_redirect_pc), 32'hFFF6);
    chk("jmp_flush", 32'(out_flush), 1);
    do_ack();
    issue(3'd6, 8'h00, 8'h00, 16'h0005, 8'h00, 16'h1234, 1'b0, 1'b0);
    chk("jr_pc", 32'(out_redirect_pc), 32'h1234);
    chk("jr_flush", 32'(out_flush), 1);
    do_ack();

    issue(3'd7, 8'h00, 8'h00, 16'h0060, 8'h04, 16'h0, 1'b0, 1'b0);
    chk("reserved_valid", 32'(out_redirect_valid), 0);
    issue(3'd1, 8'h3C, 8'h3C, 16'h0010, 8'd4, 16'h0, 1'b1, 1'b0);
    chk("stall_flush", 32'(out_flush), 0);
    chk("stall_valid", 32'(out_redirect_valid), 0);
    chk("stall_overrun", 32'(out_overrun), 0);

    issue(3'd2, 8'h01, 8'h02, 16'h0100, 8'h10, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(out_redirect_valid), 1);
      chk("hold_pc", 32'(out_redirect_pc), 32'h0111);
    end
    do_ack();
    chk("hold_released", 32'(out_redirect_valid), 0);

    issue(3'd5, 8'h00, 8'h00, 16'h0200, 8'h02, 16'h0, 1'b0, 1'b0);
    chk("req_pc", 32'(out_redirect_pc), 32'h0203);
    issue(3'd6, 8'h00, 8'h00, 16'h0000, 8'h00, 16'h3333, 1'b0, 1'b1);
    chk("ack_same_edge_pc", 32'(out_redirect_pc), 32'h3333);
    chk("ack_same_edge_valid", 32'(out_redirect_valid), 1);
    chk("ack_same_edge_overrun", 32'(out_overrun), 0);
    issue(3'd6, 8'h00, 8'h00, 16'h0000, 8'h00, 16'h4444, 1'b0, 1'b0);
    chk("overrun_pc", 32'(out_redirect_pc), 32'h4444);
    chk("overrun_set", 32'(out_overrun), 1);

    issue(3'd1, 8'h3C, 8'h3C, 16'h0010, 8'd4, 16'h0, 1'b0, 1'b0);
    chk("pre_rst_flush", 32'(out_flush), 2);
    #1;
    in_rst = 1'b0;
    #1;
    chk("async_rst_flush", 32'(out_flush), 0);
    chk("async_rst_valid", 32'(out_redirect_valid), 0);
    chk("async_rst_pc", 32'(out_redirect_pc), 0);
    chk("async_rst_overrun", 32'(out_overrun), 0);
`ifdef SWITCH_MCU_BR_STATS_EN
    chk("async_rst_taken_cnt", 32'(out_taken_cnt), 0);
    chk("async_rst_flush_cyc_cnt", 32'(out_flush_cyc_cnt), 0);
`endif
    @(negedge in_clk);
    #2;
    in_rst = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 32'(out_redirect_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
